// File: rtl/ifd_pkg.sv
// Shared types for the fetch/dispatch sequencer.
// FSM state encoding, opcode constants, opcode legality check.
package ifd_pkg;

  typedef enum logic [2:0] {
    IDLE,
    F_ADDR,
    F_READ,
    DECODE,
    EXEC,
    CLEAR
  } state_t;

  localparam logic [3:0] OP_NOP    = 4'b0000;
  localparam logic [3:0] OP_ALUI_A = 4'b0001;
  localparam logic [3:0] OP_ALUI_B = 4'b0010;
  localparam logic [3:0] OP_ALU    = 4'b0011;
  localparam logic [3:0] OP_LD     = 4'b0100;
  localparam logic [3:0] OP_ST     = 4'b0101;

  function automatic logic is_valid_op(input logic [3:0] op);
    logic ok;
    ok = 1'b0;
    unique case (1'b1)
      op == OP_ALUI_A: ok = 1'b1;
      op == OP_ALUI_B: ok = 1'b1;
      op == OP_ALU:    ok = 1'b1;
      op == OP_LD:     ok = 1'b1;
      op == OP_ST:     ok = 1'b1;
      default:         ok = 1'b0;
    endcase
    return ok;
  endfunction

endpackage

// File: rtl/ifd_watchdog.sv
// EXEC watchdog: loadable down-counter, expire when it reaches zero.
// Ports: clk, rst (async low), load, en, clr -> expire.
module ifd_watchdog #(
  parameter int unsigned TIMEOUT = 32
) (
  input  logic clk,
  input  logic rst,
  input  logic load,
  input  logic en,
  input  logic clr,
  output logic expire
);

  logic [7:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (clr)
      cnt_d = '0;
    else if (load)
      cnt_d = 8'(TIMEOUT - 1);
    else if (en && cnt_q != '0)
      cnt_d = cnt_q - 8'd1;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) cnt_q <= '0;
    else      cnt_q <= cnt_d;
  end

  assign expire = (cnt_q == '0);

endmodule

// File: rtl/instr_fetch_dispatch.sv
// Fetch/decode/dispatch sequencer feeding the execute FSMs via ir_out.
// Ports: bus/mem handshake in, bus control + ir_out + status out. Macro IFD_STEP_EN.
module instr_fetch_dispatch
  import ifd_pkg::*;
#(
  parameter int unsigned TIMEOUT  = 32,
  parameter logic [15:0] NOP_WORD = 16'h0000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [15:0] bus_in,
  input  logic        mem_ready,
  input  logic        sub_done,
  input  logic        step,
  output logic        PC_out,
  output logic        MAR_in,
  output logic        mem_rd,
  output logic        pc_inc,
  output logic [15:0] ir_out,
  output logic        exec_busy,
  output logic        illegal,
  output logic        timeout
);

  state_t      state_q, state_d;
  logic [15:0] ir_q, ir_d;
  logic        clr_cnt_q, clr_cnt_d;
  logic        pc_out_q, pc_out_d;
  logic        mar_in_q, mar_in_d;
  logic        mem_rd_q, mem_rd_d;
  logic        busy_q, busy_d;
  logic        dec_inc_q, dec_inc_d;
  logic        illegal_q, illegal_d;
  logic        wd_expire;
  logic        wd_fire;
  logic        go;
  logic [3:0]  op_d;

`ifdef IFD_STEP_EN
  logic step_q;
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) step_q <= 1'b0;
    else      step_q <= step;
  end
  assign go = step & ~step_q;
`else
  logic unused_step;
  assign unused_step = step;
  assign go = 1'b1;
`endif

  // sub_done in the expiry cycle suppresses the abort
  assign wd_fire = (state_q == EXEC) && wd_expire && !sub_done;

  always_comb begin
    state_d   = state_q;
    ir_d      = ir_q;
    clr_cnt_d = 1'b0;
    unique case (state_q)
      IDLE:   if (go) state_d = F_ADDR;
      F_ADDR: state_d = F_READ;
      F_READ: begin
        if (mem_ready) begin
          ir_d    = bus_in;
          state_d = DECODE;
        end
      end
      DECODE: begin
        if (is_valid_op(ir_q[15:12])) begin
          state_d = EXEC;
        end else if (ir_q[15:12] == OP_NOP) begin
          state_d = IDLE;
        end else begin
          state_d = CLEAR;
          ir_d    = NOP_WORD;
        end
      end
      EXEC: begin
        if (sub_done || wd_fire) begin
          state_d = CLEAR;
          ir_d    = NOP_WORD;
        end
      end
      CLEAR: begin
        ir_d      = NOP_WORD;
        clr_cnt_d = ~clr_cnt_q;
        if (clr_cnt_q) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // Outputs registered from the next state
  assign op_d = ir_d[15:12];

  always_comb begin
    pc_out_d  = (state_d == F_ADDR);
    mar_in_d  = (state_d == F_ADDR);
    mem_rd_d  = (state_d == F_READ);
    busy_d    = (state_d == EXEC);
    dec_inc_d = (state_d == DECODE) && !is_valid_op(op_d);
    illegal_d = (state_d == DECODE) && !is_valid_op(op_d)
                && (op_d != OP_NOP);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q   <= IDLE;
      ir_q      <= NOP_WORD;
      clr_cnt_q <= 1'b0;
      pc_out_q  <= 1'b0;
      mar_in_q  <= 1'b0;
      mem_rd_q  <= 1'b0;
      busy_q    <= 1'b0;
      dec_inc_q <= 1'b0;
      illegal_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      ir_q      <= ir_d;
      clr_cnt_q <= clr_cnt_d;
      pc_out_q  <= pc_out_d;
      mar_in_q  <= mar_in_d;
      mem_rd_q  <= mem_rd_d;
      busy_q    <= busy_d;
      dec_inc_q <= dec_inc_d;
      illegal_q <= illegal_d;
    end
  end

  ifd_watchdog #(
    .TIMEOUT(TIMEOUT)
  ) u_wd (
    .clk   (clk),
    .rst   (rst),
    .load  (state_q == DECODE && state_d == EXEC),
    .en    (state_q == EXEC),
    .clr   (state_d == CLEAR),
    .expire(wd_expire)
  );

  assign PC_out    = pc_out_q;
  assign MAR_in    = mar_in_q;
  assign mem_rd    = mem_rd_q;
  assign exec_busy = busy_q;
  assign illegal   = illegal_q;
  assign ir_out    = ir_q;
  assign pc_inc    = dec_inc_q | wd_fire;
  assign timeout   = wd_fire;

endmodule

// File: tb/tb_instr_fetch_dispatch.sv
// Bench for instr_fetch_dispatch: per-instruction expected trace model.
// Directed instruction list, cycle-by-cycle compare, async reset cases.
module tb_instr_fetch_dispatch;

  localparam int TO = 32;
`ifdef IFD_STEP_EN
  localparam int IDL = 3;
`else
  localparam int IDL = 1;
`endif

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic [15:0] bus_in = '0;
  logic        mem_ready = 1'b0;
  logic        sub_done = 1'b0;
  logic        step = 1'b0;
  logic        PC_out, MAR_in, mem_rd, pc_inc;
  logic [15:0] ir_out;
  logic        exec_busy, illegal, timeout;

  int checks = 0;
  int failures = 0;

  instr_fetch_dispatch #(.TIMEOUT(TO), .NOP_WORD(16'h0000)) dut (
    .clk(clk), .rst(rst), .bus_in(bus_in),
    .mem_ready(mem_ready), .sub_done(sub_done), .step(step),
    .PC_out(PC_out), .MAR_in(MAR_in), .mem_rd(mem_rd),
    .pc_inc(pc_inc), .ir_out(ir_out), .exec_busy(exec_busy),
    .illegal(illegal), .timeout(timeout)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL time_limit reached");
    $fatal(1, "time limit");
  end

  // exp = {PC_out,MAR_in,mem_rd,pc_inc,exec_busy,illegal,timeout,ir_out}
  typedef struct {
    logic [15:0] bus;
    logic        rdy;
    logic        sd;
    logic        stp;
    logic [22:0] exp;
    int          ph;
  } vec_t;

  vec_t        q[$];
  logic [15:0] m_ir = 16'h0000;

  function automatic logic [22:0] ev(bit pco, bit mar, bit rd,
      bit inc, bit busy, bit ill, bit to, logic [15:0] ir);
    return {pco, mar, rd, inc, busy, ill, to, ir};
  endfunction

  function automatic string phn(int p);
    case (p)
      0: return "idle";
      1: return "faddr";
      2: return "fread";
      3: return "decode";
      4: return "exec";
      default: return "clear";
    endcase
  endfunction

  task automatic push(logic [15:0] b, logic r, logic s, logic st,
      logic [22:0] e, int p);
    vec_t v;
    v.bus = b; v.rdy = r; v.sd = s; v.stp = st; v.exp = e; v.ph = p;
    q.push_back(v);
  endtask

  task automatic push_clear();
    m_ir = 16'h0000;
    repeat (2) push(16'h5A5A, 1'b0, 1'b0, 1'b0, ev(0,0,0,0,0,0,0,m_ir), 5);
  endtask

  // One instruction's trace. done_at: EXEC cycle (1-based) of sub_done, 0 = never.
  task automatic gen(logic [15:0] w, int waitc, int done_at, bit noise);
    int op;
`ifdef IFD_STEP_EN
    push(16'hDEAD, 1'b0, noise, 1'b0, ev(0,0,0,0,0,0,0,m_ir), 0);
    push(16'hDEAD, 1'b0, 1'b0, 1'b0, ev(0,0,0,0,0,0,0,m_ir), 0);
    push(16'hDEAD, 1'b0, 1'b0, 1'b1, ev(0,0,0,0,0,0,0,m_ir), 0);
`else
    push(16'hDEAD, 1'b0, noise, noise, ev(0,0,0,0,0,0,0,m_ir), 0);
`endif
    push(16'hBEEF, 1'b0, noise, 1'b0, ev(1,1,0,0,0,0,0,m_ir), 1);
    for (int i = 0; i < waitc; i++)
      push(16'hABC0 ^ 16'(i), 1'b0, noise, 1'b0, ev(0,0,1,0,0,0,0,m_ir), 2);
    push(w, 1'b1, 1'b0, 1'b0, ev(0,0,1,0,0,0,0,m_ir), 2);
    m_ir = w;
    op = int'(w[15:12]);
    if (op >= 1 && op <= 5) begin
      push(16'h0F0F, 1'b0, 1'b0, 1'b0, ev(0,0,0,0,0,0,0,w), 3);
      for (int k = 1; k <= TO; k++) begin
        bit sd, to, st;
        sd = (k == done_at);
        to = !sd && (k == TO);
        st = noise && (k == 2 || k == 4);
        push(16'h1111, 1'b0, sd, st, ev(0,0,0,to,1,0,to,w), 4);
        if (sd || to) break;
      end
      push_clear();
    end else if (op == 0) begin
      push(16'h0F0F, 1'b0, 1'b0, 1'b0, ev(0,0,0,1,0,0,0,w), 3);
    end else begin
      push(16'h0F0F, 1'b0, 1'b0, 1'b0, ev(0,0,0,1,0,1,0,w), 3);
      push_clear();
    end
  endtask

  task automatic check(string name, logic [22:0] got, logic [22:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%h exp=%h t=%0t", name, got, exp, $time);
    end
  endtask

  function automatic logic [22:0] outs();
    return {PC_out, MAR_in, mem_rd, pc_inc, exec_busy, illegal, timeout, ir_out};
  endfunction

  // Called at posedge+1; plays up to n entries, drops the rest.
  task automatic play(int n);
    int i;
    i = 0;
    while (q.size() > 0 && i < n) begin
      vec_t v;
      v = q.pop_front();
      bus_in = v.bus; mem_ready = v.rdy; sub_done = v.sd; step = v.stp;
      @(negedge clk);
      check($sformatf("cyc_%s", phn(v.ph)), outs(), v.exp);
      @(posedge clk); #1;
      i++;
    end
    q.delete();
    mem_ready = 1'b0; sub_done = 1'b0; step = 1'b0;
  endtask

  task automatic do_reset();
    mem_ready = 1'b0; sub_done = 1'b0; step = 1'b0;
    #1 rst = 1'b0;
    #1 check("async_reset", outs(), 23'h0);
    m_ir = 16'h0000;
    @(posedge clk); #1;
    check("reset_held", outs(), 23'h0);
    rst = 1'b1;
  endtask

  initial begin
    #1 check("reset_state", outs(), 23'h0);
    repeat (2) @(posedge clk);
    #1 rst = 1'b1;

    // ALUI dispatch, noise on sub_done outside EXEC and step in EXEC
    gen(16'h1083, 2, 9, 1'b1);
    checks++;
    if (q.size() != IDL + 1 + 3 + 1 + 9 + 2) begin
      failures++;
      $display("FAIL model_len got=%0d exp=%0d", q.size(), IDL + 16);
    end
    play(1000);

    gen(16'h0000, 0, 0, 1'b0);
    play(1000);
    gen(16'hF123, 1, 0, 1'b0);
    play(1000);

    // Timeout: EXEC cycle 32 carries the abort pulse
    gen(16'h3A5C, 0, 0, 1'b0);
    checks++;
    if (q[IDL + 3 + 31].exp[16] !== 1'b1 ||
        q[IDL + 3 + 31].exp[19] !== 1'b1 ||
        q[IDL + 3 + 30].exp[16] !== 1'b0) begin
      failures++;
      $display("FAIL model_timeout_slot got=%b exp=1", q[IDL + 34].exp[16]);
    end
    play(1000);

    // sub_done on the expiry cycle wins
    gen(16'h2777, 0, TO, 1'b0);
    play(1000);

    gen(16'h4001, 0, 1, 1'b0);
    play(1000);
    gen(16'h5002, 3, 5, 1'b1);
    play(1000);
    gen(16'h6000, 0, 0, 1'b0);
    play(1000);
    gen(16'hE000, 2, 0, 1'b0);
    play(1000);

    // Reset during F_READ
    gen(16'h1234, 4, 3, 1'b0);
    play(IDL + 1 + 2);
    do_reset();
    gen(16'h1083, 1, 4, 1'b0);
    play(1000);

    // Reset during EXEC
    gen(16'h3003, 0, 0, 1'b0);
    play(IDL + 3 + 3);
    do_reset();
    gen(16'h2010, 0, 2, 1'b0);
    play(1000);
    gen(16'h0000, 1, 0, 1'b0);
    play(1000);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
